bbox_scanner: RTL and testbench
===============================

BBOX_SCANNER -- requirements
Module: bbox_scanner

Interface
REQ-001 SHALL have parameter COORD_W, default 16: unsigned width of each pixel coordinate.
REQ-002 SHALL have parameter ID_W, default 16: triangle tag width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port vld_in, input, 1: upstream bounding-box valid.
REQ-006 SHALL have port rdy_in, output, 1: block can accept a bounding box.
REQ-007 SHALL have port bbox_xmin, bbox_ymin, bbox_xmax, bbox_ymax, input, COORD_W each: inclusive box limits.
REQ-008 SHALL have port tri_id, input, ID_W: tag carried onto every emitted pixel.
REQ-009 SHALL have port vld_out, output, 1: pixel valid toward downstream FIFO.
REQ-010 SHALL have port rdy_out, input, 1: downstream FIFO can accept.
REQ-011 SHALL have port data_out, output, ID_W+2*COORD_W+1: packed {tag, last, y, x}, x in LSBs.
REQ-012 SHALL have port busy, output, 1: high while in SCAN.
REQ-013 SHALL have port drop_cnt, output, 16: count of discarded empty boxes.

Function
REQ-014 SHALL implement two states: IDLE and SCAN.
REQ-015 In IDLE: rdy_in=1, vld_out=0.
REQ-016 In SCAN: rdy_in=0, vld_out=1.
REQ-017 In IDLE, vld_in=1 with xmin<=xmax and ymin<=ymax: latch box and tri_id, load x=xmin, y=ymin, and go to SCAN next cycle; first pixel valid one cycle after acceptance.
REQ-018 In IDLE, vld_in=1 with xmin>xmax or ymin>ymax (unsigned compare): consume the box, stay in IDLE, emit nothing, and increment drop_cnt.
REQ-019 drop_cnt SHALL saturate at 0xFFFF.
REQ-020 Pixels SHALL be emitted in raster order: x ascending within a row, rows y ascending; each (x,y) in the box exactly once.
REQ-021 A pixel transfers only on a cycle with vld_out=1 and rdy_out=1.
REQ-022 Pixel advance on transfer: if x!=xmax, x+1; else x=xmin and y+1.
REQ-023 data_out and vld_out SHALL be registered outputs.
REQ-024 data_out SHALL be held stable while vld_out=1 and rdy_out=0.
REQ-025 The last bit SHALL be 1 only on pixel (xmax,ymax).
REQ-026 On transfer of the last pixel: return to IDLE next cycle; exactly one idle cycle between consecutive boxes.
REQ-027 Advance logic SHALL compare before incrementing, so limits of 2^COORD_W-1 never wrap the counters.
REQ-028 Single-pixel box (xmin=xmax, ymin=ymax) SHALL emit one pixel with last=1.
REQ-029 rdy_out SHALL be ignored in IDLE.
REQ-030 vld_in SHALL be ignored in SCAN; an upstream box offered during SCAN waits until IDLE.
REQ-031 Throughput: one pixel per cycle when rdy_out is held high.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force IDLE, vld_out=0, rdy_in=1, busy=0, drop_cnt=0, and data_out=0.
REQ-033 Reset asserted mid-SCAN SHALL abandon the box; no further pixels after rst_n deasserts until a new box is accepted.
REQ-034 First box acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 Box (2,3)-(4,4), tag 0x5, rdy_out=1 -> 6 pixels on consecutive cycles: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); last=1 only on (4,4); tag 0x5 on all.
REQ-036 Box (0,0)-(1,1), rdy_out toggling 1,0,1,0,... -> 4 pixels in order; data_out unchanged during every rdy_out=0 cycle; no duplicates or losses.
REQ-037 Box (5,0)-(4,0) -> no vld_out, drop_cnt 0->1; 0x10000 empty boxes -> drop_cnt stays 0xFFFF.
REQ-038 Box (0xFFFE,0xFFFF)-(0xFFFF,0xFFFF) -> exactly 2 pixels, last on (0xFFFF,0xFFFF); then IDLE; no wrap to 0.
REQ-039 Box (0,0)-(9,9) with rst_n pulsed low after 17 pixels -> vld_out=0 at once; no pixels after release; next box (1,1)-(1,1) -> single pixel with last=1.
REQ-040 Two boxes offered back-to-back: (0,0)-(0,0) then (7,7)-(7,7) -> two single pixels separated by exactly one vld_out=0 cycle.

Source files
------------

// File: rtl/bbox_scanner.sv
// Bounding-box rasteriser: accepts an inclusive pixel box plus a triangle tag
// and streams every covered pixel in raster order to a downstream FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | ready for a new box; empty boxes are consumed and counted
// SCAN    | presenting one pixel per cycle on data_out while rdy_out allows
module bbox_scanner #(
    parameter int COORD_W = 16,
    parameter int ID_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vld_in,
    output logic                      rdy_in,
    input  logic [COORD_W-1:0]        bbox_xmin,
    input  logic [COORD_W-1:0]        bbox_ymin,
    input  logic [COORD_W-1:0]        bbox_xmax,
    input  logic [COORD_W-1:0]        bbox_ymax,
    input  logic [ID_W-1:0]           tri_id,
    output logic                      vld_out,
    input  logic                      rdy_out,
    output logic [ID_W+2*COORD_W:0]   data_out,
    output logic                      busy,
    output logic [15:0]               drop_cnt
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    logic               state;
    logic [COORD_W-1:0] xmin_r;
    logic [COORD_W-1:0] xmax_r;
    logic [COORD_W-1:0] ymax_r;
    logic [COORD_W-1:0] x_cur;
    logic [COORD_W-1:0] y_cur;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic [ID_W-1:0]    tag_cur;
    logic               box_empty;
    logic               accept;
    logic               drop;
    logic               at_last;
    logic               nxt_last;
    logic               first_last;

    // The current pixel lives in the output register itself; no separate counters.
    assign x_cur   = data_out[COORD_W-1:0];
    assign y_cur   = data_out[2*COORD_W-1:COORD_W];
    assign tag_cur = data_out[ID_W+2*COORD_W:2*COORD_W+1];

    assign box_empty  = (bbox_xmin > bbox_xmax) || (bbox_ymin > bbox_ymax);
    assign accept     = (state == ST_IDLE) && vld_in && !box_empty;
    assign drop       = (state == ST_IDLE) && vld_in && box_empty;
    assign at_last    = (x_cur == xmax_r) && (y_cur == ymax_r);
    assign first_last = (bbox_xmin == bbox_xmax) && (bbox_ymin == bbox_ymax);
    assign nxt_last   = (x_nxt == xmax_r) && (y_nxt == ymax_r);

    assign rdy_in  = (state == ST_IDLE);
    assign vld_out = (state == ST_SCAN);
    assign busy    = (state == ST_SCAN);

    // Raster advance; compare against the limit first so a limit of all-ones never wraps.
    always_comb begin
        x_nxt = x_cur;
        y_nxt = y_cur;
        if (x_cur != xmax_r) begin
            x_nxt = x_cur + COORD_W'(1);
        end else begin
            x_nxt = xmin_r;
            y_nxt = y_cur + COORD_W'(1);
        end
    end

    // Box acceptance, pixel stepping and return to IDLE after the last transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            xmin_r   <= '0;
            xmax_r   <= '0;
            ymax_r   <= '0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_SCAN;
                        xmin_r   <= bbox_xmin;
                        xmax_r   <= bbox_xmax;
                        ymax_r   <= bbox_ymax;
                        data_out <= {tri_id, first_last, bbox_ymin, bbox_xmin};
                    end
                end
                ST_SCAN: begin
                    if (rdy_out) begin
                        if (at_last) begin
                            state    <= ST_IDLE;
                            data_out <= '0;
                        end else begin
                            data_out <= {tag_cur, nxt_last, y_nxt, x_nxt};
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of empty boxes consumed in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bbox_scanner.sv
// Randomised and directed bench for bbox_scanner against a loop-based pixel model.
module tb_bbox_scanner;

    localparam int CW = 16;
    localparam int IW = 16;
    localparam int DW = IW + 2*CW + 1;

    logic          clk;
    logic          rst_n;
    logic          vld_in;
    logic          rdy_in;
    logic [CW-1:0] bbox_xmin;
    logic [CW-1:0] bbox_ymin;
    logic [CW-1:0] bbox_xmax;
    logic [CW-1:0] bbox_ymax;
    logic [IW-1:0] tri_id;
    logic          vld_out;
    logic          rdy_out;
    logic [DW-1:0] data_out;
    logic          busy;
    logic [15:0]   drop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    int exp_drop = 0;
    logic [DW-1:0] exp_q[$];

    bbox_scanner #(.COORD_W(CW), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in),
        .bbox_xmin(bbox_xmin), .bbox_ymin(bbox_ymin),
        .bbox_xmax(bbox_xmax), .bbox_ymax(bbox_ymax),
        .tri_id(tri_id), .vld_out(vld_out), .rdy_out(rdy_out),
        .data_out(data_out), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one box for one cycle and update the reference model.
    task automatic offer(input int x0, input int y0, input int x1, input int y1, input int tag);
        logic lst;
        @(negedge clk);
        vec_cnt++;
        if (rdy_in !== 1'b1) begin
            err_cnt++;
            $display("FAIL offer_rdy_in got %b want 1", rdy_in);
        end
        bbox_xmin = x0[CW-1:0];
        bbox_ymin = y0[CW-1:0];
        bbox_xmax = x1[CW-1:0];
        bbox_ymax = y1[CW-1:0];
        tri_id    = tag[IW-1:0];
        vld_in    = 1'b1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        if (x0 > x1 || y0 > y1) begin
            if (exp_drop < 65535) exp_drop++;
        end else begin
            for (int y = y0; y <= y1; y++) begin
                for (int x = x0; x <= x1; x++) begin
                    lst = (x == x1) && (y == y1);
                    exp_q.push_back({tag[IW-1:0], lst, y[CW-1:0], x[CW-1:0]});
                end
            end
        end
    endtask

    // Drain the expected pixel queue; mode 0 rdy high, 1 toggling, 2 random.
    task automatic scan_check(input string name, input int mode);
        logic [DW-1:0] held;
        logic [DW-1:0] exp;
        bit            hold_pending;
        int            cyc;
        hold_pending = 0;
        held = '0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            if (hold_pending) begin
                vec_cnt++;
                if (data_out !== held) begin
                    err_cnt++;
                    $display("FAIL %s_hold got %h want %h", name, data_out, held);
                end
            end
            hold_pending = 0;
            case (mode)
                0:       rdy_out = 1'b1;
                1:       rdy_out = (cyc % 2 == 0);
                default: rdy_out = 1'($urandom_range(0, 1));
            endcase
            vec_cnt++;
            if (busy !== vld_out || (mode == 0 && vld_out !== 1'b1)) begin
                err_cnt++;
                $display("FAIL %s_vld got vld=%b busy=%b want vld=1 busy=vld", name, vld_out, busy);
            end
            if (vld_out === 1'b1 && rdy_out) begin
                exp = exp_q.pop_front();
                vec_cnt++;
                if (data_out !== exp) begin
                    err_cnt++;
                    $display("FAIL %s_pixel got %h want %h", name, data_out, exp);
                end
            end else if (vld_out === 1'b1) begin
                held = data_out;
                hold_pending = 1;
            end
            cyc++;
        end
        vec_cnt++;
        if (exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL %s_timeout got %0d pixels left want 0", name, exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        vec_cnt++;
        if (vld_out !== 1'b0 || rdy_in !== 1'b1 || busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_idle got vld=%b rdy_in=%b busy=%b want 0 1 0", name, vld_out, rdy_in, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (vld_out !== 1'b0 || rdy_in !== 1'b1 || busy !== 1'b0 || drop_cnt !== 16'h0 || data_out !== '0) begin
            err_cnt++;
            $display("FAIL reset got vld=%b rdy=%b busy=%b drop=%h data=%h want 0 1 0 0 0",
                     vld_out, rdy_in, busy, drop_cnt, data_out);
        end
        #21 rst_n = 1'b1;
        exp_drop = 0;
    endtask

    task automatic test_basic();
        rdy_out = 1'b1;
        offer(2, 3, 4, 4, 5);
        scan_check("basic", 0);
    endtask

    task automatic test_stall();
        offer(0, 0, 1, 1, 16'h00A1);
        scan_check("stall", 1);
    endtask

    task automatic test_drop();
        offer(5, 0, 4, 0, 9);
        repeat (3) begin
            @(negedge clk);
            vec_cnt++;
            if (vld_out !== 1'b0) begin
                err_cnt++;
                $display("FAIL drop_vld got %b want 0", vld_out);
            end
        end
        vec_cnt++;
        if (drop_cnt !== exp_drop[15:0]) begin
            err_cnt++;
            $display("FAIL drop_cnt got %h want %h", drop_cnt, exp_drop[15:0]);
        end
    endtask

    task automatic test_edge();
        offer(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1234);
        scan_check("edge", 0);
        repeat (3) begin
            @(negedge clk);
            vec_cnt++;
            if (vld_out !== 1'b0) begin
                err_cnt++;
                $display("FAIL edge_nowrap got vld=%b data=%h want vld=0", vld_out, data_out);
            end
        end
    endtask

    task automatic test_midscan_reset();
        logic [DW-1:0] exp;
        rdy_out = 1'b1;
        offer(0, 0, 9, 9, 16'h0042);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            vec_cnt++;
            if (vld_out !== 1'b1 || data_out !== exp) begin
                err_cnt++;
                $display("FAIL rst17_pixel got vld=%b %h want 1 %h", vld_out, data_out, exp);
            end
        end
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (vld_out !== 1'b0 || rdy_in !== 1'b1 || busy !== 1'b0 || data_out !== '0 || drop_cnt !== 16'h0) begin
            err_cnt++;
            $display("FAIL rst_async got vld=%b rdy=%b busy=%b data=%h drop=%h want 0 1 0 0 0",
                     vld_out, rdy_in, busy, data_out, drop_cnt);
        end
        #10 rst_n = 1'b1;
        exp_drop = 0;
        repeat (10) begin
            @(negedge clk);
            vec_cnt++;
            if (vld_out !== 1'b0) begin
                err_cnt++;
                $display("FAIL rst_after got vld=%b want 0", vld_out);
            end
        end
        offer(1, 1, 1, 1, 16'h0077);
        scan_check("rst_single", 0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        exp_a = {16'h00AA, 1'b1, 16'd0, 16'd0};
        exp_b = {16'h00BB, 1'b1, 16'd7, 16'd7};
        rdy_out = 1'b1;
        @(negedge clk);
        bbox_xmin = 0; bbox_ymin = 0; bbox_xmax = 0; bbox_ymax = 0; tri_id = 16'h00AA;
        vld_in = 1'b1;
        @(negedge clk);
        bbox_xmin = 7; bbox_ymin = 7; bbox_xmax = 7; bbox_ymax = 7; tri_id = 16'h00BB;
        vec_cnt++;
        if (vld_out !== 1'b1 || data_out !== exp_a) begin
            err_cnt++;
            $display("FAIL b2b_first got vld=%b %h want 1 %h", vld_out, data_out, exp_a);
        end
        @(negedge clk);
        vec_cnt++;
        if (vld_out !== 1'b0 || rdy_in !== 1'b1) begin
            err_cnt++;
            $display("FAIL b2b_gap got vld=%b rdy_in=%b want 0 1", vld_out, rdy_in);
        end
        @(negedge clk);
        vld_in = 1'b0;
        vec_cnt++;
        if (vld_out !== 1'b1 || data_out !== exp_b) begin
            err_cnt++;
            $display("FAIL b2b_second got vld=%b %h want 1 %h", vld_out, data_out, exp_b);
        end
        @(negedge clk);
        vec_cnt++;
        if (vld_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_end got vld=%b want 0", vld_out);
        end
    endtask

    task automatic test_random();
        int x0, y0, w, h, tag;
        for (int n = 0; n < 30; n++) begin
            w   = $urandom_range(0, 4);
            h   = $urandom_range(0, 3);
            x0  = (n % 6 == 5) ? 65535 - w : $urandom_range(0, 65535 - w);
            y0  = (n % 7 == 6) ? 65535 - h : $urandom_range(0, 65535 - h);
            tag = $urandom_range(0, 65535);
            if ($urandom_range(0, 4) == 0 && w > 0) begin
                offer(x0 + w, y0, x0, y0 + h, tag);
                @(negedge clk);
                vec_cnt++;
                if (vld_out !== 1'b0 || drop_cnt !== exp_drop[15:0]) begin
                    err_cnt++;
                    $display("FAIL rand_drop got vld=%b drop=%h want 0 %h", vld_out, drop_cnt, exp_drop[15:0]);
                end
            end else begin
                offer(x0, y0, x0 + w, y0 + h, tag);
                scan_check("rand", 2);
            end
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        bbox_xmin = 3; bbox_ymin = 9; bbox_xmax = 3; bbox_ymax = 8;
        vld_in = 1'b1;
        repeat (65536) @(posedge clk);
        #1 vld_in = 1'b0;
        exp_drop = (exp_drop + 65536 > 65535) ? 65535 : exp_drop + 65536;
        @(negedge clk);
        vec_cnt++;
        if (drop_cnt !== exp_drop[15:0] || vld_out !== 1'b0) begin
            err_cnt++;
            $display("FAIL saturate got drop=%h vld=%b want %h 0", drop_cnt, vld_out, exp_drop[15:0]);
        end
        offer(8, 0, 7, 0, 1);
        @(negedge clk);
        vec_cnt++;
        if (drop_cnt !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL saturate_hold got %h want ffff", drop_cnt);
        end
    endtask

    initial begin
        vld_in = 1'b0; rdy_out = 1'b0; tri_id = '0;
        bbox_xmin = '0; bbox_ymin = '0; bbox_xmax = '0; bbox_ymax = '0;
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_edge();
        test_midscan_reset();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
